dmux4way16_router: RTL and testbench

Registered 1-to-4 router for 16-bit words: the distributing counterpart to the 4-way 16-bit multiplexer. One valid/ready source stream is routed by `sel` to one of four destination channels (a, b, c, d), each backed by a one-entry holding register with its own valid/ready handshake. It sits between a single producer, such as the CPU data bus or a memory-mapped write port, and four independent consumers.

---
 rtl/dmux4way16_router.sv | 110 +++++++++++
 tb/tb_dmux4way16_router.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmux4way16_router.sv
// Registered 1-to-4 valid/ready router: sel steers each input word into one of four one-entry channel registers.
// Optional per-channel delivery counters are enabled by defining DMUX4WAY16_ROUTER_COUNT_EN.
module dmux4way16_router #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready
`ifdef DMUX4WAY16_ROUTER_COUNT_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b,
    output logic [15:0]      cnt_c,
    output logic [15:0]      cnt_d
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state [4];
    logic [WIDTH-1:0] data  [4];
    logic [3:0]       rdy;
    logic [3:0]       vld;
    logic             take;

    always_comb begin
        rdy = {d_ready, c_ready, b_ready, a_ready};
        vld = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            vld[i] = (state[i] == FULL);
        end
    end

    // A full channel that drains this cycle can be refilled in the same cycle.
    assign in_ready = ~vld[sel] | rdy[sel];
    assign take     = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= EMPTY;
                data[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (take && (sel == 2'(i))) begin
                    state[i] <= FULL;
                    data[i]  <= in;
                end else if (state[i] == FULL && rdy[i]) begin
                    state[i] <= EMPTY;
                end
            end
        end
    end

    assign a       = data[0];
    assign b       = data[1];
    assign c       = data[2];
    assign d       = data[3];
    assign a_valid = vld[0];
    assign b_valid = vld[1];
    assign c_valid = vld[2];
    assign d_valid = vld[3];

`ifdef DMUX4WAY16_ROUTER_COUNT_EN
    logic [15:0] cnt [4];

    // Clear wins over a simultaneous drain; counters wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cnt_clr) begin
                    cnt[i] <= '0;
                end else if (vld[i] && rdy[i]) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    assign cnt_a = cnt[0];
    assign cnt_b = cnt[1];
    assign cnt_c = cnt[2];
    assign cnt_d = cnt[3];
`endif

endmodule

// File: tb/tb_dmux4way16_router.sv
// Scoreboard bench for dmux4way16_router: per-channel expected-word queues filled on accept, drained by a monitor.
// Counter checks are compiled in when DMUX4WAY16_ROUTER_COUNT_EN is defined.
module tb_dmux4way16_router;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b, c, d;
    logic        a_valid, b_valid, c_valid, d_valid;
    logic [3:0]  rdy;
    logic        cnt_clr;

    wire [15:0] dout [4];
    wire [3:0]  vout = {d_valid, c_valid, b_valid, a_valid};
    assign dout[0] = a;
    assign dout[1] = b;
    assign dout[2] = c;
    assign dout[3] = d;

`ifdef DMUX4WAY16_ROUTER_COUNT_EN
    logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
    wire  [15:0] cnt_o [4];
    assign cnt_o[0] = cnt_a;
    assign cnt_o[1] = cnt_b;
    assign cnt_o[2] = cnt_c;
    assign cnt_o[3] = cnt_d;
`endif

    dmux4way16_router #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in(in), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d),
        .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
        .a_ready(rdy[0]), .b_ready(rdy[1]), .c_ready(rdy[2]), .d_ready(rdy[3])
`ifdef DMUX4WAY16_ROUTER_COUNT_EN
        , .cnt_clr(cnt_clr), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] expq [4][$];
    logic [15:0] last_acc [4];
    logic [15:0] cnt_m [4];
    int          drains [4];
    logic        held = 1'b0;

    task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch=%0d actual=%h required=%h t=%0t", name, ch, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            expq[i].delete();
            last_acc[i] = 16'h0;
            cnt_m[i]    = 16'h0;
        end
        held = 1'b0;
    endtask

    // Monitor: compares channel outputs with the model and retires words on drain handshakes.
    always @(negedge clk) begin
        if (!reset) begin
            for (int ch = 0; ch < 4; ch++) begin
                check("valid", ch, 32'(vout[ch]), 32'(expq[ch].size() != 0));
                check("data", ch, 32'(dout[ch]), 32'(last_acc[ch]));
`ifdef DMUX4WAY16_ROUTER_COUNT_EN
                check("cnt", ch, 32'(cnt_o[ch]), 32'(cnt_m[ch]));
`endif
                if (expq[ch].size() != 0 && rdy[ch]) begin
                    logic [15:0] got;
                    got = expq[ch].pop_front();
                    check("order", ch, 32'(dout[ch]), 32'(got));
                    drains[ch]++;
                    cnt_m[ch] = cnt_m[ch] + 16'd1;
                end
            end
        end
    end

    // Acceptance model: a channel takes a word if it is empty or is being drained this cycle.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            logic model_rdy;
            model_rdy = (expq[sel].size() == 0) || rdy[sel];
            check("in_ready", int'(sel), 32'(in_ready), 32'(model_rdy));
            if (in_valid && model_rdy) begin
                expq[sel].push_back(in);
                last_acc[sel] = in;
            end
            held = in_valid && !model_rdy;
`ifdef DMUX4WAY16_ROUTER_COUNT_EN
            if (cnt_clr) begin
                for (int i = 0; i < 4; i++) cnt_m[i] = 16'h0;
            end
`endif
        end
    end

    task automatic cyc(input logic v, input logic [1:0] s, input logic [15:0] dd, input logic [3:0] r);
        in_valid = v;
        sel      = s;
        in       = dd;
        rdy      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        reset    = 1'b1;
        in       = '0;
        sel      = '0;
        in_valid = 1'b0;
        rdy      = '0;
        cnt_clr  = 1'b0;
        for (int i = 0; i < 4; i++) drains[i] = 0;
        clear_model();
        #12;
        for (int ch = 0; ch < 4; ch++) begin
            check("rst_valid", ch, 32'(vout[ch]), 32'h0);
            check("rst_data", ch, 32'(dout[ch]), 32'h0);
`ifdef DMUX4WAY16_ROUTER_COUNT_EN
            check("rst_cnt", ch, 32'(cnt_o[ch]), 32'h0);
`endif
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_in_ready", 0, 32'(in_ready), 32'h1);

        // Single word to c, visible for exactly one cycle.
        cyc(1'b1, 2'd2, 16'h1234, 4'b0100);
        check("c_after_accept", 2, {15'h0, c_valid, c}, {15'h0, 1'b1, 16'h1234});
        cyc(1'b0, 2'd0, 16'h0, 4'b0100);
        check("c_after_drain", 2, 32'(c_valid), 32'h0);
        check("others_idle", 0, {a_valid, b_valid, d_valid, a | b | d}, 32'h0);

        // Blocked b must not stall d.
        cyc(1'b1, 2'd1, 16'hBEEF, 4'b0000);
        in_valid = 1'b1;
        sel      = 2'd1;
        in       = 16'hCAFE;
        #1;
        check("b_blocked", 1, 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("b_hold", 1, 32'(b), 32'hBEEF);
        sel = 2'd3;
        #1;
        check("d_unblocked", 3, 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("d_got", 3, {15'h0, d_valid, d}, {15'h0, 1'b1, 16'hCAFE});
        cyc(1'b0, 2'd0, 16'h0, 4'b1111);
        cyc(1'b0, 2'd0, 16'h0, 4'b0000);

        // Back-to-back streaming into a.
        cyc(1'b1, 2'd0, 16'h00FF, 4'b0000);
        d0 = drains[0];
        for (int k = 1; k <= 16; k++) cyc(1'b1, 2'd0, 16'(k), 4'b0001);
        check("stream_last", 0, {15'h0, a_valid, a}, {15'h0, 1'b1, 16'h0010});
        cyc(1'b0, 2'd0, 16'h0, 4'b0001);
        check("stream_drains", 0, 32'(drains[0] - d0), 32'd17);

        // Asynchronous reset with a and d full and a word in flight.
        cyc(1'b1, 2'd0, 16'hAAAA, 4'b0000);
        cyc(1'b1, 2'd3, 16'hDDDD, 4'b0000);
        in_valid = 1'b1;
        sel      = 2'd1;
        in       = 16'h1111;
        @(negedge clk);
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        check("async_valid", 0, 32'(vout), 32'h0);
        check("async_data", 0, 32'(a | b | c | d), 32'h0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rel_in_ready", 0, 32'(in_ready), 32'h1);
        cyc(1'b1, 2'd2, 16'h5555, 4'b0000);
        check("rel_route", 2, {vout, c}, {12'h0, 4'b0100, 16'h5555});
        cyc(1'b0, 2'd0, 16'h0, 4'b1111);

        // Random traffic; a stalled word is held stable until accepted.
        for (int n = 0; n < 1000; n++) begin
            logic [3:0] r;
            r       = 4'($urandom);
            cnt_clr = ($urandom_range(0, 63) == 0);
            if (held) cyc(in_valid, sel, in, r);
            else cyc(($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom), r);
        end
        cnt_clr = 1'b0;
        cyc(1'b0, 2'd0, 16'h0, 4'b1111);
        cyc(1'b0, 2'd0, 16'h0, 4'b0000);

`ifdef DMUX4WAY16_ROUTER_COUNT_EN
        // Clear with a simultaneous drain.
        cyc(1'b1, 2'd0, 16'h0042, 4'b0000);
        cnt_clr = 1'b1;
        cyc(1'b0, 2'd0, 16'h0, 4'b0001);
        cnt_clr = 1'b0;
        check("clr_priority", 0, 32'(cnt_a), 32'h0);
        // Wrap: 0xFFFF drains then one more.
        for (int i = 0; i < 65535; i++) cyc(1'b1, 2'd0, 16'(i), 4'b0001);
        cyc(1'b0, 2'd0, 16'h0, 4'b0001);
        check("cnt_ffff", 0, 32'(cnt_a), 32'h0000FFFF);
        cyc(1'b1, 2'd0, 16'h0007, 4'b0000);
        cyc(1'b0, 2'd0, 16'h0, 4'b0001);
        check("cnt_wrap", 0, 32'(cnt_a), 32'h0);
`endif

        cyc(1'b0, 2'd0, 16'h0, 4'b0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
